// File: rtl/mutative_setup_ctrl.sv
// Associativity reconfiguration controller: drains the cache, writes back dirty lines,
// invalidates every physical line, then commits the new setup value.
module mutative_setup_ctrl #(
    parameter int LINES     = 64,
    parameter int IDX_BITS  = 6,
    parameter int MAX_SETUP = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                setup_valid,
    input  logic                setup_update,
    output logic                setup_ready,
    output logic [1:0]          setup,
    input  logic                cache_idle,
    output logic                cache_stall,
    output logic [IDX_BITS-1:0] meta_idx,
    output logic                meta_rd,
    input  logic                meta_valid,
    input  logic                meta_dirty,
    output logic                meta_inv,
    output logic                wb_req,
    input  logic                wb_ack
);

    // state   | meaning
    // IDLE    | waiting for a request, cache running
    // DRAIN   | stalled, waiting for the cache FSM to go idle
    // READ    | metadata read strobe for line meta_idx
    // CHECK   | metadata returned, pick writeback or invalidate
    // WB      | writeback of line meta_idx in flight
    // INV     | invalidate line meta_idx, advance or finish
    // COMMIT  | apply new setup, one-cycle setup_ready
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_READ, S_CHECK, S_WB, S_INV, S_COMMIT
    } state_t;

    localparam logic [1:0]          SETUP_MAX = 2'(MAX_SETUP);
    localparam logic [IDX_BITS-1:0] IDX_LAST  = IDX_BITS'(LINES - 1);

    state_t              state;
    state_t              state_nx;
    logic                dir;
    logic                noop;
    logic                req_noop;
    logic [IDX_BITS-1:0] idx;

    assign req_noop = setup_update ? (setup == SETUP_MAX) : (setup == 2'd0);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (setup_valid) state_nx = req_noop ? S_COMMIT : S_DRAIN;
            S_DRAIN:  if (cache_idle) state_nx = S_READ;
            S_READ:   state_nx = S_CHECK;
            S_CHECK:  state_nx = (meta_valid && meta_dirty) ? S_WB : S_INV;
            S_WB:     if (wb_ack) state_nx = S_INV;
            S_INV:    state_nx = (idx == IDX_LAST) ? S_COMMIT : S_READ;
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            setup <= 2'd0;
            idx   <= '0;
            dir   <= 1'b0;
            noop  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (setup_valid) begin
                        dir  <= setup_update;
                        noop <= req_noop;
                    end
                end
                S_DRAIN: begin
                    if (cache_idle) idx <= '0;
                end
                S_INV: begin
                    if (idx != IDX_LAST) idx <= idx + 1'b1;
                end
                S_COMMIT: begin
                    idx  <= '0;
                    noop <= 1'b0;
                    // saturation was already resolved in IDLE, so this never wraps
                    if (!noop) setup <= dir ? setup + 2'd1 : setup - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // a no-op request passes through COMMIT without stalling the cache
    assign cache_stall = (state != S_IDLE) && !noop;
    assign setup_ready = (state == S_COMMIT);
    assign meta_rd     = (state == S_READ);
    assign meta_inv    = (state == S_INV);
    assign wb_req      = (state == S_WB);
    assign meta_idx    = idx;

endmodule
